router_pkt_tx: RTL and testbench

Source-side packet transmitter for the router input port. It takes a packet request (destination address, payload length) and a byte stream of payload. It serializes header, payload and parity onto the router's pkt_valid/data_in interface and honours the router busy back-pressure. It sits between a traffic source (host logic or bench driver) and the router top.

---
 rtl/router_pkg.sv | 34 +++
 rtl/router_parity_acc.sv | 23 ++
 rtl/router_pkt_tx.sv | 158 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header helpers for the router packet transmit/receive paths.
// Header byte layout: length in the upper six bits, destination port in the lower two.
package router_pkg;

    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } tx_state_t;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

    function automatic logic [7:0] hdr_pack(input logic [LEN_W-1:0] len,
                                            input logic [ADDR_W-1:0] addr);
        hdr_t h;
        h.len  = len;
        h.addr = addr;
        return h;
    endfunction

    function automatic hdr_t hdr_unpack(input logic [7:0] b);
        return hdr_t'(b);
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Byte-wide XOR parity accumulator: clear wins over load, load wins over accumulate.
// Result is registered; the value is available the cycle after the update.
module router_parity_acc (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic       xor_en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            acc <= 8'h00;
        end else if (load) begin
            acc <= din;
        end else if (xor_en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Serialises header, payload and parity onto the router input; one byte per cycle when not busy.
// router_busy freezes data_out/pkt_valid; src_ready (combinational) stalls the source in step.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_LEN    = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  dest_addr,
    input  logic [5:0]  pay_len,
    input  logic        corrupt_parity,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic        router_busy,
    output logic        pkt_valid,
    output logic [7:0]  data_out,
    output logic        tx_active,
    output logic        done,
    output logic        reject,
    output logic [15:0] pkt_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [3:0]       GAP_L     = 4'(GAP_CYCLES);

    tx_state_t        state;
    logic [LEN_W-1:0] len_cnt;
    logic [3:0]       gap_cnt;
    logic             corrupt_q;
    logic             loaded;
    logic [7:0]       parity;

    logic             start_ok;
    logic             consume;
    logic             acc_load;
    logic             acc_clear;
    logic [7:0]       acc_din;

    always_comb begin
        start_ok = (dest_addr != ILLEGAL_ADDR) && (pay_len != '0) && (pay_len <= MAX_LEN_L);
    end

    // The header hand-off fetches the first payload byte so no byte is ever shown twice.
    always_comb begin
        src_ready = 1'b0;
        case (state)
            HEADER:  src_ready = !router_busy;
            PAYLOAD: src_ready = (len_cnt != '0) && (!loaded || !router_busy);
            default: src_ready = 1'b0;
        endcase
    end

    always_comb begin
        consume   = src_ready && src_valid;
        acc_load  = (state == IDLE) && start && start_ok;
        acc_clear = (state == PARITY) && !router_busy;
        acc_din   = acc_load ? hdr_pack(pay_len, dest_addr) : src_data;
    end

    router_parity_acc u_parity (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .load   (acc_load),
        .xor_en (consume),
        .din    (acc_din),
        .acc    (parity)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            tx_active <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
            pkt_count <= 16'h0000;
            len_cnt   <= '0;
            gap_cnt   <= 4'h0;
            corrupt_q <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            data_out  <= hdr_pack(pay_len, dest_addr);
                            pkt_valid <= 1'b1;
                            len_cnt   <= pay_len;
                            corrupt_q <= corrupt_parity;
                            loaded    <= 1'b1;
                            tx_active <= 1'b1;
                            state     <= HEADER;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!router_busy) begin
                        state <= PAYLOAD;
                        if (src_valid) begin
                            data_out <= src_data;
                            len_cnt  <= len_cnt - 1'b1;
                            loaded   <= 1'b1;
                        end else begin
                            loaded <= 1'b0;
                        end
                    end
                end
                PAYLOAD: begin
                    // loaded=0 means data_out was already accepted and is only being held.
                    if (loaded && !router_busy && (len_cnt == '0)) begin
                        data_out  <= corrupt_q ? ~parity : parity;
                        pkt_valid <= 1'b0;
                        state     <= PARITY;
                    end else if (consume) begin
                        data_out <= src_data;
                        len_cnt  <= len_cnt - 1'b1;
                        loaded   <= 1'b1;
                    end else if (loaded && !router_busy) begin
                        loaded <= 1'b0;
                    end
                end
                PARITY: begin
                    if (!router_busy) begin
                        done      <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                        gap_cnt   <= GAP_L;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt   <= 4'h0;
                        tx_active <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pkt_valid <= 1'b0;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: basic, back-pressure, reject, corrupt parity,
// mid-packet reset and back-to-back packets, each checked against hand-computed bytes.
module tb_router_pkt_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  dest_addr;
    logic [5:0]  pay_len;
    logic        corrupt_parity;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        src_ready;
    logic        router_busy;
    logic        pkt_valid;
    logic [7:0]  data_out;
    logic        tx_active;
    logic        done;
    logic        reject;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_buf [0:7];
    int         src_idx = 0;
    int         src_n   = 0;
    int         gap;

    always #5 clock = ~clock;

    router_pkt_tx #(.GAP_CYCLES(2), .MAX_LEN(63)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .dest_addr      (dest_addr),
        .pay_len        (pay_len),
        .corrupt_parity (corrupt_parity),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .router_busy    (router_busy),
        .pkt_valid      (pkt_valid),
        .data_out       (data_out),
        .tx_active      (tx_active),
        .done           (done),
        .reject         (reject),
        .pkt_count      (pkt_count)
    );

    assign src_valid = (src_idx < src_n);
    assign src_data  = src_buf[src_idx & 7];

    // Source model: advance one byte per observed handshake.
    initial begin
        logic hs;
        forever begin
            @(negedge clock);
            hs = src_valid && src_ready;
            @(posedge clock);
            #1;
            if (hs) src_idx++;
        end
    end

    // A source that is asked for data must always have it.
    initial begin
        forever begin
            @(negedge clock);
            if (src_ready === 1'b1) begin
                checks++;
                assert (src_valid === 1'b1) else begin
                    errors++;
                    $error("FAIL underrun observed src_valid=%b expected 1", src_valid);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_src(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
        src_buf[0] = b0;
        src_buf[1] = b1;
        src_buf[2] = b2;
        src_buf[3] = b3;
        src_idx    = 0;
        src_n      = n;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (tx_active === 1'b0) break;
            tick();
        end
        chk(tag, 16'(tx_active), 16'h0);
    endtask

    task automatic send(input logic [1:0] a, input logic [5:0] l, input logic c);
        dest_addr      = a;
        pay_len        = l;
        corrupt_parity = c;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dest_addr = 2'd0;
        pay_len = 6'd0;
        corrupt_parity = 1'b0;
        router_busy = 1'b0;
        for (int i = 0; i < 8; i++) src_buf[i] = 8'h00;
        tick();
        tick();
        chk("rst_pkt_valid", 16'(pkt_valid), 16'h0);
        chk("rst_data_out",  16'(data_out),  16'h0);
        chk("rst_tx_active", 16'(tx_active), 16'h0);
        chk("rst_done",      16'(done),      16'h0);
        chk("rst_reject",    16'(reject),    16'h0);
        chk("rst_count",     pkt_count,      16'h0);
        chk("rst_src_ready", 16'(src_ready), 16'h0);
        reset = 1'b0;
        tick();

        // Basic packet: header 0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D.
        load_src(8'h11, 8'h22, 8'h33, 8'h00, 3);
        send(2'd1, 6'd3, 1'b0);
        chk("b_hdr",    16'({pkt_valid, data_out}), 16'h10D);
        chk("b_active", 16'(tx_active), 16'h1);
        tick(); chk("b_p0", 16'({pkt_valid, data_out}), 16'h111);
        tick(); chk("b_p1", 16'({pkt_valid, data_out}), 16'h122);
        tick(); chk("b_p2", 16'({pkt_valid, data_out}), 16'h133);
        tick(); chk("b_par", 16'({pkt_valid, data_out}), 16'h00D);
        chk("b_done_early", 16'(done), 16'h0);
        tick(); chk("b_done", 16'(done), 16'h1);
        chk("b_count", pkt_count, 16'd1);
        tick(); chk("b_done_pulse", 16'(done), 16'h0);
        wait_idle("b_idle");

        // Back-pressure while 0x22 is on the bus.
        load_src(8'h11, 8'h22, 8'h33, 8'h00, 3);
        send(2'd1, 6'd3, 1'b0);
        chk("bp_hdr", 16'({pkt_valid, data_out}), 16'h10D);
        tick(); chk("bp_p0", 16'({pkt_valid, data_out}), 16'h111);
        tick(); chk("bp_p1", 16'({pkt_valid, data_out}), 16'h122);
        router_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold", 16'({pkt_valid, data_out}), 16'h122);
        end
        router_busy = 1'b0;
        tick(); chk("bp_p2", 16'({pkt_valid, data_out}), 16'h133);
        tick(); chk("bp_par", 16'({pkt_valid, data_out}), 16'h00D);
        chk("bp_consumed", 16'(src_idx), 16'd3);
        tick(); chk("bp_done", 16'(done), 16'h1);
        chk("bp_count", pkt_count, 16'd2);
        wait_idle("bp_idle");

        // Illegal requests.
        send(2'd3, 6'd5, 1'b0);
        chk("rj_addr", 16'({reject, pkt_valid, tx_active}), 16'b100);
        tick(); chk("rj_pulse", 16'(reject), 16'h0);
        send(2'd0, 6'd0, 1'b0);
        chk("rj_len", 16'({reject, pkt_valid, tx_active}), 16'b100);
        tick(); chk("rj_count", pkt_count, 16'd2);

        // Error injection: parity inverted to 0xF2.
        load_src(8'h11, 8'h22, 8'h33, 8'h00, 3);
        send(2'd1, 6'd3, 1'b1);
        chk("ci_hdr", 16'({pkt_valid, data_out}), 16'h10D);
        tick(); tick(); tick();
        chk("ci_p2", 16'({pkt_valid, data_out}), 16'h133);
        tick(); chk("ci_par", 16'({pkt_valid, data_out}), 16'h0F2);
        tick(); chk("ci_count", pkt_count, 16'd3);
        wait_idle("ci_idle");

        // Reset after the second payload byte is presented.
        load_src(8'h11, 8'h22, 8'h33, 8'h00, 3);
        send(2'd1, 6'd3, 1'b0);
        tick(); tick();
        chk("mr_p1", 16'({pkt_valid, data_out}), 16'h122);
        reset = 1'b1;
        tick();
        chk("mr_state", 16'({pkt_valid, tx_active, done}), 16'b000);
        chk("mr_data", 16'(data_out), 16'h00);
        reset = 1'b0;
        tick();
        chk("mr_no_done", 16'(done), 16'h0);
        // Follow-up packet: header 0x0A, parity 0x0A^0xAA^0x55 = 0xF5.
        load_src(8'hAA, 8'h55, 8'h00, 8'h00, 2);
        send(2'd2, 6'd2, 1'b0);
        chk("mr2_hdr", 16'({pkt_valid, data_out}), 16'h10A);
        tick(); chk("mr2_p0", 16'({pkt_valid, data_out}), 16'h1AA);
        tick(); chk("mr2_p1", 16'({pkt_valid, data_out}), 16'h155);
        tick(); chk("mr2_par", 16'({pkt_valid, data_out}), 16'h0F5);
        tick(); chk("mr2_count", 16'({done, pkt_count[14:0]}), 16'h8001);
        wait_idle("mr2_idle");

        // Back-to-back with start held: header 0x05, payload 0x5A, parity 0x5F.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        load_src(8'h5A, 8'h5A, 8'h00, 8'h00, 2);
        dest_addr = 2'd1;
        pay_len = 6'd1;
        corrupt_parity = 1'b0;
        start = 1'b1;
        tick(); chk("bb_hdr0", 16'({pkt_valid, data_out}), 16'h105);
        tick(); chk("bb_p0",   16'({pkt_valid, data_out}), 16'h15A);
        tick(); chk("bb_par0", 16'({pkt_valid, data_out}), 16'h05F);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pkt_valid !== 1'b0) break;
            gap++;
        end
        start = 1'b0;
        chk("bb_hdr1", 16'({pkt_valid, data_out}), 16'h105);
        chk("bb_gap", 16'(gap >= 2), 16'h1);
        tick(); chk("bb_p1",   16'({pkt_valid, data_out}), 16'h15A);
        tick(); chk("bb_par1", 16'({pkt_valid, data_out}), 16'h05F);
        tick(); chk("bb_count", pkt_count, 16'd2);
        wait_idle("bb_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
